// File: rtl/plotfour_game_ctrl.sv
// -----------------------------------------------------------------------------
// plotfour_game_ctrl
//
// Sequential game controller for the 4x5 plot-four board. It sequences the two
// players' turns, edge-detects their move strobes, validates and commits each
// selected square into the blue (player one) or red (player two) occupancy
// register, then scans the 17 winning lines one per cycle against the mover's
// board.
//
// Ports
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   start       in   level; rising edge starts/restarts a game (any state)
//   p_one       in   level; rising edge = player one submits square
//   p_two       in   level; rising edge = player two submits square
//   square      in   [5:0] selected square index, row*COLS + col
//   blue        out  [19:0] player one occupancy
//   red         out  [19:0] player two occupancy
//   turn        out  1 = player one to move, 0 = player two
//   p_one_win   out  sticky player one win flag
//   p_two_win   out  sticky player two win flag
//   draw        out  sticky board-full-no-winner flag
//   illegal     out  one-cycle pulse on a rejected submission
//   busy        out  high while committing or scanning lines
//   move_count  out  [4:0] squares filled, 0..20
//
// Timing: a move edge sampled at the end of cycle T is committed during T+1
// (bit visible in T+2); line k is scanned in cycle T+2+k, so a win on line k
// is flagged in T+3+k and, without a win, the turn toggles in T+19.
// -----------------------------------------------------------------------------
module plotfour_game_ctrl #(
   parameter int unsigned ROWS    = 4,
   parameter int unsigned COLS    = 5,
   parameter int unsigned TIMEOUT = 250000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        p_one,
   input  logic        p_two,
   input  logic [5:0]  square,
   output logic [19:0] blue,
   output logic [19:0] red,
   output logic        turn,
   output logic        p_one_win,
   output logic        p_two_win,
   output logic        draw,
   output logic        illegal,
   output logic        busy,
   output logic [4:0]  move_count
);

   localparam logic [5:0]  N_SQ_6     = 6'(ROWS * COLS);
   localparam logic [4:0]  N_SQ_5     = 5'(ROWS * COLS);
   localparam logic [4:0]  COLS_5     = 5'(COLS);
   localparam logic [4:0]  LAST_LINE  = 5'd16;
   localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_COMMIT,
      S_CHECK,
      S_DONE
   } state_e;

   // Square mask of winning line idx, in scan order:
   //   0-7   horizontals, row = idx/2, start column = idx%2
   //   8-12  verticals, columns 0..4
   //   13-14 down-right diagonals from squares 0 and 1
   //   15-16 down-left diagonals from squares 3 and 4
   function automatic logic [19:0] line_mask(input logic [4:0] idx);
      logic [19:0] m;
      logic [4:0]  base;
      m    = '0;
      base = '0;
      if (idx <= 5'd7) begin
         base = ({3'd0, idx[2:1]} * COLS_5) + {4'd0, idx[0]};
         m    = 20'h0000F << base;
      end else if (idx <= 5'd12) begin
         m = 20'h08421 << (idx - 5'd8);
      end else begin
         case (idx)
            5'd13:   m = 20'h41041;
            5'd14:   m = 20'h82082;
            5'd15:   m = 20'h08888;
            5'd16:   m = 20'h11110;
            default: m = '0;
         endcase
      end
      return m;
   endfunction

   state_e      state_q, state_d;
   logic [19:0] blue_q, blue_d;
   logic [19:0] red_q, red_d;
   logic        turn_q, turn_d;
   logic        p1_win_q, p1_win_d;
   logic        p2_win_q, p2_win_d;
   logic        draw_q, draw_d;
   logic        illegal_q, illegal_d;
   logic [4:0]  move_cnt_q, move_cnt_d;
   logic [4:0]  sq_q, sq_d;
   logic [4:0]  line_q, line_d;
   logic [31:0] timer_q, timer_d;
   logic        start_prev_q, p1_prev_q, p2_prev_q;

   logic        start_edge, p1_edge, p2_edge;
   logic        on_turn_edge, off_turn_edge;
   logic [19:0] occupancy;
   logic        occupied;
   logic [19:0] mover_board;
   logic [19:0] cur_mask;

   assign start_edge    = start & ~start_prev_q;
   assign p1_edge       = p_one & ~p1_prev_q;
   assign p2_edge       = p_two & ~p2_prev_q;
   assign on_turn_edge  = turn_q ? p1_edge : p2_edge;
   assign off_turn_edge = turn_q ? p2_edge : p1_edge;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, whatever the statement order.
      if (!resetn) begin
         state_q      <= S_IDLE;
         blue_q       <= '0;
         red_q        <= '0;
         turn_q       <= 1'b1;
         p1_win_q     <= 1'b0;
         p2_win_q     <= 1'b0;
         draw_q       <= 1'b0;
         illegal_q    <= 1'b0;
         move_cnt_q   <= '0;
         sq_q         <= '0;
         line_q       <= '0;
         timer_q      <= '0;
         start_prev_q <= 1'b0;
         p1_prev_q    <= 1'b0;
         p2_prev_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         blue_q       <= blue_d;
         red_q        <= red_d;
         turn_q       <= turn_d;
         p1_win_q     <= p1_win_d;
         p2_win_q     <= p2_win_d;
         draw_q       <= draw_d;
         illegal_q    <= illegal_d;
         move_cnt_q   <= move_cnt_d;
         sq_q         <= sq_d;
         line_q       <= line_d;
         timer_q      <= timer_d;
         start_prev_q <= start;
         p1_prev_q    <= p_one;
         p2_prev_q    <= p_two;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // through this block can leave a value unassigned and infer a latch.
      state_d     = state_q;
      blue_d      = blue_q;
      red_d       = red_q;
      turn_d      = turn_q;
      p1_win_d    = p1_win_q;
      p2_win_d    = p2_win_q;
      draw_d      = draw_q;
      illegal_d   = 1'b0;
      move_cnt_d  = move_cnt_q;
      sq_d        = sq_q;
      line_d      = line_q;
      timer_d     = timer_q;

      occupancy   = blue_q | red_q;
      occupied    = occupancy[square[4:0]];
      mover_board = turn_q ? blue_q : red_q;
      cur_mask    = line_mask(line_q);

      if (start_edge) begin
         // A start edge restarts from any state and wins over a move edge.
         state_d    = S_WAIT;
         blue_d     = '0;
         red_d      = '0;
         turn_d     = 1'b1;
         p1_win_d   = 1'b0;
         p2_win_d   = 1'b0;
         draw_d     = 1'b0;
         move_cnt_d = '0;
         line_d     = '0;
         timer_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Moves are ignored until a game is started.
            end

            S_WAIT: begin
               // Idle timer: forfeit the turn after TIMEOUT waiting cycles.
               if (TIMEOUT != 0) begin
                  if (timer_q == TIMEOUT_M1) begin
                     turn_d  = ~turn_q;
                     timer_d = '0;
                  end else begin
                     timer_d = timer_q + 32'd1;
                  end
               end

               if (on_turn_edge) begin
                  // Range check first so the occupancy lookup is only
                  // meaningful for indices that exist on the board.
                  if (square >= N_SQ_6) begin
                     illegal_d = 1'b1;
                  end else if (occupied) begin
                     illegal_d = 1'b1;
                  end else begin
                     // An accepted move beats a coincident timeout.
                     sq_d    = square[4:0];
                     turn_d  = turn_q;
                     timer_d = '0;
                     state_d = S_COMMIT;
                  end
               end else if (off_turn_edge) begin
                  illegal_d = 1'b1;
               end
            end

            S_COMMIT: begin
               if (turn_q) begin
                  blue_d[sq_q] = 1'b1;
               end else begin
                  red_d[sq_q] = 1'b1;
               end
               move_cnt_d = move_cnt_q + 5'd1;
               line_d     = '0;
               state_d    = S_CHECK;
            end

            S_CHECK: begin
               if ((mover_board & cur_mask) == cur_mask) begin
                  if (turn_q) begin
                     p1_win_d = 1'b1;
                  end else begin
                     p2_win_d = 1'b1;
                  end
                  state_d = S_DONE;
               end else if (line_q == LAST_LINE) begin
                  if (move_cnt_q == N_SQ_5) begin
                     draw_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     turn_d  = ~turn_q;
                     timer_d = '0;
                     state_d = S_WAIT;
                  end
               end else begin
                  line_d = line_q + 5'd1;
               end
            end

            S_DONE: begin
               // Board and flags hold until start or reset.
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      busy       = (state_q == S_COMMIT) || (state_q == S_CHECK);
      blue       = blue_q;
      red        = red_q;
      turn       = turn_q;
      p_one_win  = p1_win_q;
      p_two_win  = p2_win_q;
      draw       = draw_q;
      illegal    = illegal_q;
      move_count = move_cnt_q;
   end

endmodule

// File: tb/tb_plotfour_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_plotfour_game_ctrl
//
// Directed bench for plotfour_game_ctrl. A main instance uses the default
// timeout; a second instance with TIMEOUT=10 exercises the turn forfeit.
// Inputs are driven on the falling edge and outputs sampled on falling edges.
// -----------------------------------------------------------------------------
module tb_plotfour_game_ctrl;

   logic        clk;
   logic        resetn;
   logic        start, p_one, p_two;
   logic [5:0]  square;
   logic [19:0] blue, red;
   logic        turn, p_one_win, p_two_win, draw, illegal, busy;
   logic [4:0]  move_count;

   logic        start_t, p_one_t, p_two_t;
   logic [5:0]  square_t;
   logic [19:0] blue_t, red_t;
   logic        turn_t, p_one_win_t, p_two_win_t, draw_t, illegal_t, busy_t;
   logic [4:0]  move_count_t;

   int n_checks;
   int n_errors;

   // Non-winning fill: final board rows B B R R B / R R B B R / repeat.
   logic [5:0] blue_seq [10] = '{6'd0, 6'd1, 6'd4, 6'd7, 6'd8,
                                 6'd10, 6'd11, 6'd14, 6'd17, 6'd18};
   logic [5:0] red_seq  [10] = '{6'd2, 6'd3, 6'd5, 6'd6, 6'd9,
                                 6'd12, 6'd13, 6'd15, 6'd16, 6'd19};

   plotfour_game_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .p_one      (p_one),
      .p_two      (p_two),
      .square     (square),
      .blue       (blue),
      .red        (red),
      .turn       (turn),
      .p_one_win  (p_one_win),
      .p_two_win  (p_two_win),
      .draw       (draw),
      .illegal    (illegal),
      .busy       (busy),
      .move_count (move_count)
   );

   plotfour_game_ctrl #(.TIMEOUT(10)) dut_to (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start_t),
      .p_one      (p_one_t),
      .p_two      (p_two_t),
      .square     (square_t),
      .blue       (blue_t),
      .red        (red_t),
      .turn       (turn_t),
      .p_one_win  (p_one_win_t),
      .p_two_win  (p_two_win_t),
      .draw       (draw_t),
      .illegal    (illegal_t),
      .busy       (busy_t),
      .move_count (move_count_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle strobe; returns on the falling edge after the sampling edge.
   task automatic press(input logic one, input logic two, input logic [5:0] sq);
      @(negedge clk);
      square = sq;
      p_one  = one;
      p_two  = two;
      @(negedge clk);
      p_one  = 1'b0;
      p_two  = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Press and let the full line scan finish so the turn has passed.
   task automatic move(input logic one, input logic [5:0] sq);
      press(one, ~one, sq);
      wait_cycles(18);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      resetn   = 1'b0;
      start    = 1'b0;
      p_one    = 1'b0;
      p_two    = 1'b0;
      square   = '0;
      start_t  = 1'b0;
      p_one_t  = 1'b0;
      p_two_t  = 1'b0;
      square_t = '0;

      // ---- reset state ----
      wait_cycles(2);
      check("rst_blue", 32'(blue), 32'h0);
      check("rst_red", 32'(red), 32'h0);
      check("rst_turn", 32'(turn), 32'h1);
      check("rst_flags", {28'd0, p_one_win, p_two_win, draw, illegal}, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_count", 32'(move_count), 32'h0);
      resetn = 1'b1;
      wait_cycles(1);

      // ---- moves before start are ignored ----
      press(1'b1, 1'b0, 6'd3);
      check("idle_illegal", 32'(illegal), 32'h0);
      wait_cycles(2);
      check("idle_blue", 32'(blue), 32'h0);

      // ---- reset in the middle of a line scan ----
      pulse_start();
      press(1'b1, 1'b0, 6'd0);
      check("commit_busy", 32'(busy), 32'h1);
      wait_cycles(2);
      check("midchk_busy", 32'(busy), 32'h1);
      check("midchk_blue", 32'(blue), 32'h1);
      resetn = 1'b0;
      #1;
      check("arst_blue", 32'(blue), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_turn", 32'(turn), 32'h1);
      check("arst_count", 32'(move_count), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      press(1'b1, 1'b0, 6'd2);
      check("arst_mv_illegal", 32'(illegal), 32'h0);
      wait_cycles(3);
      check("arst_mv_blue", 32'(blue), 32'h0);
      check("arst_mv_busy", 32'(busy), 32'h0);

      // ---- player one wins on line 0 ----
      pulse_start();
      move(1'b1, 6'd0);
      move(1'b0, 6'd5);
      move(1'b1, 6'd1);
      move(1'b0, 6'd6);
      move(1'b1, 6'd2);
      move(1'b0, 6'd7);
      check("win_pre_turn", 32'(turn), 32'h1);
      press(1'b1, 1'b0, 6'd3);
      wait_cycles(1);
      check("win_t2_flag", 32'(p_one_win), 32'h0);
      wait_cycles(1);
      check("win_t3_flag", 32'(p_one_win), 32'h1);
      check("win_blue", 32'(blue), 32'h0000F);
      check("win_red", 32'(red), 32'h000E0);
      check("win_count", 32'(move_count), 32'd7);
      check("win_p2", 32'(p_two_win), 32'h0);
      wait_cycles(20);
      check("win_turn", 32'(turn), 32'h1);
      press(1'b0, 1'b1, 6'd8);
      check("done_illegal", 32'(illegal), 32'h0);
      wait_cycles(20);
      check("done_red", 32'(red), 32'h000E0);
      check("done_flag", 32'(p_one_win), 32'h1);

      // ---- illegal submissions ----
      pulse_start();
      check("rs_blue", 32'(blue), 32'h0);
      check("rs_win", 32'(p_one_win), 32'h0);
      check("rs_turn", 32'(turn), 32'h1);
      press(1'b1, 1'b0, 6'd25);
      check("oor_illegal", 32'(illegal), 32'h1);
      wait_cycles(1);
      check("oor_pulse_end", 32'(illegal), 32'h0);
      check("oor_turn", 32'(turn), 32'h1);
      check("oor_busy", 32'(busy), 32'h0);
      move(1'b1, 6'd0);
      check("p1_0_turn", 32'(turn), 32'h0);
      press(1'b0, 1'b1, 6'd0);
      check("occ_illegal", 32'(illegal), 32'h1);
      wait_cycles(2);
      check("occ_red", 32'(red), 32'h0);
      check("occ_turn", 32'(turn), 32'h0);
      press(1'b1, 1'b0, 6'd7);
      check("off_illegal", 32'(illegal), 32'h1);
      wait_cycles(2);
      check("off_blue", 32'(blue), 32'h1);
      check("off_red", 32'(red), 32'h0);

      // ---- simultaneous edges on player one's turn ----
      pulse_start();
      press(1'b1, 1'b1, 6'd4);
      check("both_illegal", 32'(illegal), 32'h0);
      wait_cycles(1);
      check("both_blue", 32'(blue), 32'h00010);
      check("both_red", 32'(red), 32'h0);
      wait_cycles(16);
      check("both_t18_turn", 32'(turn), 32'h1);
      wait_cycles(1);
      check("both_t19_turn", 32'(turn), 32'h0);

      // ---- full board without a line -> draw ----
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         move(1'b1, blue_seq[i]);
         move(1'b0, red_seq[i]);
      end
      check("draw_flag", 32'(draw), 32'h1);
      check("draw_wins", {30'd0, p_one_win, p_two_win}, 32'h0);
      check("draw_count", 32'(move_count), 32'd20);
      check("draw_blue", 32'(blue), 32'h64D93);
      check("draw_red", 32'(red), 32'h9B26C);
      pulse_start();
      check("clr_draw", 32'(draw), 32'h0);
      check("clr_blue", 32'(blue), 32'h0);
      check("clr_red", 32'(red), 32'h0);
      check("clr_count", 32'(move_count), 32'h0);
      check("clr_turn", 32'(turn), 32'h1);

      // ---- turn forfeit on the TIMEOUT=10 instance ----
      @(negedge clk);
      start_t = 1'b1;
      @(negedge clk);
      start_t = 1'b0;
      wait_cycles(9);
      check("to_before", 32'(turn_t), 32'h1);
      wait_cycles(1);
      check("to_turn", 32'(turn_t), 32'h0);
      check("to_board", 32'(blue_t | red_t), 32'h0);
      @(negedge clk);
      square_t = 6'd6;
      p_two_t  = 1'b1;
      @(negedge clk);
      p_two_t  = 1'b0;
      check("to_mv_illegal", 32'(illegal_t), 32'h0);
      wait_cycles(1);
      check("to_mv_red", 32'(red_t), 32'h00040);
      check("to_mv_count", 32'(move_count_t), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
